// File: rtl/dice_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dice_pe_seq_ctrl
// Desc   : Config capture and thread-issue sequencer for a row of DICE PEs.
//          Define DICE_PE_CTRL_PERF_EN to add run/stall performance counters.
// Rev    : 1.0 - initial release
// ============================================================================

module dice_pe_seq_ctrl #(
  parameter int NUM_PE = 4,
  parameter int LAT_W  = 8,
  parameter int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [IDX_W-1:0]     cfg_pe_idx,
  input  logic [31:0]          cfg_opcode,
  input  logic                 cfg_out_sel,
  input  logic                 cfg_last,
  input  logic                 start,
  input  logic [15:0]          num_threads,
  input  logic [LAT_W-1:0]     pipe_lat,
  input  logic                 stall,
  output logic [NUM_PE*32-1:0] pe_opcode,
  output logic [NUM_PE-1:0]    pe_out_sel,
  output logic                 dff_input_mode,
  output logic                 dff_output_mode,
  output logic                 thread_valid,
  output logic [15:0]          thread_id,
  output logic                 busy,
  output logic                 done,
`ifdef DICE_PE_CTRL_PERF_EN
  output logic [31:0]          perf_run_cycles,
  output logic [31:0]          perf_stall_cycles,
`endif
  output logic                 cfg_loaded
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [NUM_PE*32-1:0] r_opcode;
  logic [NUM_PE-1:0]   r_out_sel;
  logic                r_cfg_loaded;
  logic [15:0]         r_num;
  logic [15:0]         r_issued;
  logic [LAT_W-1:0]    r_lat;
  logic [LAT_W-1:0]    r_cnt;
  logic                r_thread_valid;
  logic [15:0]         r_thread_id;
  logic                r_mode_in;
  logic                r_mode_out;

  logic w_cfg_fire;
  logic w_launch;
  logic w_launch_run;
  logic w_more;
  logic w_issue_run;
  logic w_issue;

  assign w_cfg_fire   = cfg_valid & cfg_ready;
  assign w_launch     = (r_state == c_IDLE) & start & r_cfg_loaded & ~w_cfg_fire;
  assign w_launch_run = w_launch & (num_threads != 16'd0);
  // r_issued counts threads already presented, so it is also the next id
  assign w_more       = (r_issued != r_num);
  assign w_issue_run  = (r_state == c_RUN) & w_more & ~stall;
  assign w_issue      = w_launch_run | w_issue_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_launch) w_next_state = w_launch_run ? c_RUN : c_DONE;
      c_RUN:   if (!w_more) w_next_state = (r_lat == '0) ? c_DONE : c_DRAIN;
      c_DRAIN: if (r_cnt == LAT_W'(1)) w_next_state = c_DONE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == c_IDLE);
    busy      = (r_state != c_IDLE);
    done      = (r_state == c_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode     <= '0;
      r_out_sel    <= '0;
      r_cfg_loaded <= 1'b0;
    end else if (w_cfg_fire) begin
      // out-of-range indices match no slot and are silently dropped
      for (int i = 0; i < NUM_PE; i++) begin
        if (cfg_pe_idx == IDX_W'(i)) begin
          r_opcode[32*i +: 32] <= cfg_opcode;
          r_out_sel[i]         <= cfg_out_sel;
        end
      end
      r_cfg_loaded <= cfg_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num          <= '0;
      r_issued       <= '0;
      r_lat          <= '0;
      r_cnt          <= '0;
      r_thread_valid <= 1'b0;
      r_thread_id    <= '0;
      r_mode_in      <= 1'b0;
      r_mode_out     <= 1'b0;
    end else begin
      r_thread_valid <= w_issue;
      r_mode_in      <= r_mode_in ^ w_issue;
      r_mode_out     <= r_mode_in;
      if (w_launch) begin
        r_num    <= num_threads;
        r_lat    <= pipe_lat;
        r_issued <= w_launch_run ? 16'd1 : 16'd0;
        if (w_launch_run) r_thread_id <= '0;
      end else if (w_issue_run) begin
        r_thread_id <= r_issued;
        r_issued    <= r_issued + 16'd1;
      end
      if ((r_state == c_RUN) && !w_more) r_cnt <= r_lat;
      else if (r_state == c_DRAIN)       r_cnt <= r_cnt - LAT_W'(1);
    end
  end

`ifdef DICE_PE_CTRL_PERF_EN
  logic [31:0] r_perf_run;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_run   <= '0;
      r_perf_stall <= '0;
    end else if (w_launch) begin
      r_perf_run   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (busy && (r_perf_run != '1)) r_perf_run <= r_perf_run + 32'd1;
      if ((r_state == c_RUN) && w_more && stall && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_run_cycles   = r_perf_run;
  assign perf_stall_cycles = r_perf_stall;
`endif

  assign pe_opcode       = r_opcode;
  assign pe_out_sel      = r_out_sel;
  assign cfg_loaded      = r_cfg_loaded;
  assign thread_valid    = r_thread_valid;
  assign thread_id       = r_thread_id;
  assign dff_input_mode  = r_mode_in;
  assign dff_output_mode = r_mode_out;

endmodule

`default_nettype wire

// File: tb/tb_dice_pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dice_pe_seq_ctrl
// Desc   : Directed scoreboard bench for dice_pe_seq_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================

module tb_dice_pe_seq_ctrl;

  localparam int NUM_PE = 4;
  localparam int LAT_W  = 8;
  localparam int IDX_W  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_valid, cfg_ready, cfg_out_sel, cfg_last, start, stall;
  logic [IDX_W-1:0]     cfg_pe_idx;
  logic [31:0]          cfg_opcode;
  logic [15:0]          num_threads, thread_id;
  logic [LAT_W-1:0]     pipe_lat;
  logic [NUM_PE*32-1:0] pe_opcode;
  logic [NUM_PE-1:0]    pe_out_sel;
  logic                 dff_input_mode, dff_output_mode, thread_valid, busy, done, cfg_loaded;
`ifdef DICE_PE_CTRL_PERF_EN
  logic [31:0]          perf_run_cycles, perf_stall_cycles;
`endif

  dice_pe_seq_ctrl #(.NUM_PE(NUM_PE), .LAT_W(LAT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pe_idx(cfg_pe_idx),
    .cfg_opcode(cfg_opcode), .cfg_out_sel(cfg_out_sel), .cfg_last(cfg_last),
    .start(start), .num_threads(num_threads), .pipe_lat(pipe_lat), .stall(stall),
    .pe_opcode(pe_opcode), .pe_out_sel(pe_out_sel),
    .dff_input_mode(dff_input_mode), .dff_output_mode(dff_output_mode),
    .thread_valid(thread_valid), .thread_id(thread_id),
    .busy(busy), .done(done),
`ifdef DICE_PE_CTRL_PERF_EN
    .perf_run_cycles(perf_run_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
    .cfg_loaded(cfg_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    logic [15:0] id;
    bit          mode;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   exp_mode = 1'b0;

  localparam logic [127:0] c_OPS = 128'h00000014_00000013_00000012_00000011;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_thread(input int id, input int at);
    exp_t e;
    exp_mode  = ~exp_mode;
    e.is_done = 1'b0;
    e.id      = 16'(id);
    e.mode    = exp_mode;
    e.at      = at;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(input int at);
    exp_t e;
    e.is_done = 1'b1;
    e.id      = '0;
    e.mode    = 1'b0;
    e.at      = at;
    exp_q.push_back(e);
  endfunction

  task automatic monitor();
    bit   prev_in = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_in = 1'b0;
      end else begin
        check("dff_output_mode", dff_output_mode, prev_in);
        prev_in = dff_input_mode;
        if (thread_valid || done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: thread_valid=%0b done=%0b id=%0d required none (cycle %0d)",
                     thread_valid, done, thread_id, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_is_done", done, e.is_done);
            check("event_cycle", cyc, e.at);
            if (!e.is_done) begin
              check("thread_id", thread_id, e.id);
              check("thread_mode", dff_input_mode, e.mode);
            end
          end
        end
      end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pe_opcode"}, pe_opcode, '0);
    check({tag, "_pe_out_sel"}, pe_out_sel, '0);
    check({tag, "_cfg_loaded"}, cfg_loaded, 0);
    check({tag, "_in_mode"}, dff_input_mode, 0);
    check({tag, "_out_mode"}, dff_output_mode, 0);
    check({tag, "_thread_valid"}, thread_valid, 0);
    check({tag, "_thread_id"}, thread_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic cfg_beat(input logic [IDX_W-1:0] idx, input logic [31:0] op,
                          input logic sel, input logic last, input logic with_start);
    @(posedge clk); #2;
    cfg_valid = 1'b1; cfg_pe_idx = idx; cfg_opcode = op;
    cfg_out_sel = sel; cfg_last = last;
    start = with_start; num_threads = 16'd2; pipe_lat = 8'd1;
    @(posedge clk); #2;
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  // stall_at: relative cycle whose thread presentation is blocked (0 = none)
  task automatic run_launch(input int n, input int l, input int stall_at,
                            input int start_at, input int cfg_at);
    int c0, t, tl, total;
    @(posedge clk); #2;
    c0 = cyc;
    tl = 0;
    if (n == 0) begin
      push_done(c0 + 1);
      total = 3;
    end else begin
      t = 1;
      for (int k = 0; k < n; k++) begin
        if (k > 0) begin
          t++;
          if (t == stall_at) t++;
        end
        push_thread(k, c0 + t);
      end
      tl = t;
      push_done(c0 + tl + l + 1);
      total = tl + l + 3;
    end
    start = 1'b1; num_threads = 16'(n); pipe_lat = LAT_W'(l);
    for (int r = 1; r <= total; r++) begin
      @(posedge clk); #2;
      start     = (r == start_at);
      stall     = (r == stall_at - 1);
      cfg_valid = (r == cfg_at);
      cfg_pe_idx = '0; cfg_opcode = 32'hdead_beef; cfg_out_sel = 1'b0; cfg_last = 1'b0;
    end
  endtask

  initial begin
    int c0;
    cfg_valid = 1'b0; cfg_pe_idx = '0; cfg_opcode = '0; cfg_out_sel = 1'b0;
    cfg_last = 1'b0; start = 1'b0; num_threads = '0; pipe_lat = '0; stall = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("cfg_ready_after_reset", cfg_ready, 1);

    // start with no config loaded is ignored
    start = 1'b1; num_threads = 16'd2; pipe_lat = 8'd1;
    @(posedge clk); #2;
    start = 1'b0;
    check("start_unloaded_busy", busy, 0);
    repeat (5) @(posedge clk);

    cfg_beat(3'd0, 32'h11, 1'b1, 1'b0, 1'b0);
    check("cfg_loaded_partial", cfg_loaded, 0);
    cfg_beat(3'd1, 32'h12, 1'b0, 1'b0, 1'b0);
    cfg_beat(3'd2, 32'h13, 1'b1, 1'b0, 1'b0);
    cfg_beat(3'd3, 32'h14, 1'b1, 1'b1, 1'b0);
    check("cfg_pe_opcode", pe_opcode, c_OPS);
    check("cfg_pe_out_sel", pe_out_sel, 4'b1101);
    check("cfg_loaded_full", cfg_loaded, 1);

    // out-of-range beat with a simultaneous start
    cfg_beat(3'd5, 32'hffff_ffff, 1'b0, 1'b1, 1'b1);
    check("start_with_cfg_busy", busy, 0);
    check("idx5_pe_opcode", pe_opcode, c_OPS);
    check("idx5_pe_out_sel", pe_out_sel, 4'b1101);
    check("idx5_cfg_loaded", cfg_loaded, 1);
    repeat (4) @(posedge clk);

    run_launch(3, 2, 0, 0, 2);
    check("run_cfg_frozen", pe_opcode, c_OPS);
    check("run_idle_busy", busy, 0);
    check("run_idle_cfg_ready", cfg_ready, 1);

    run_launch(3, 2, 2, 2, 0);
`ifdef DICE_PE_CTRL_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 1);
    check("perf_run_cycles", perf_run_cycles, 7);
`endif

    run_launch(0, 5, 0, 0, 0);
    check("n0_cfg_loaded_kept", cfg_loaded, 1);
    run_launch(1, 0, 0, 0, 0);

    // reset in cycle 2 of a 10-thread run
    @(posedge clk); #2;
    c0 = cyc;
    push_thread(0, c0 + 1);
    push_thread(1, c0 + 2);
    start = 1'b1; num_threads = 16'd10; pipe_lat = 8'd3;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    exp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("abort_busy", busy, 0);
    check("abort_cfg_loaded", cfg_loaded, 0);
    check("abort_cfg_ready", cfg_ready, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
